// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, forwarding and pipeline-control unit for the 5-stage MIPS datapath.
// Keeps a shadow copy of the EX/MEM/WB instructions and drives stall, bubble, flush and bypass selects.
module pipe_hazard_ctrl #(
  parameter int AW     = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [AW-1:0]    id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             mem_branch_taken,
  output logic             stall,
  output logic             idex_bubble,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             id_byp_a,
  output logic             id_byp_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          memread;
    logic          use_rs;
    logic          use_rt;
    logic [AW-1:0] dst;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
  } slot_t;

  localparam logic [CNT_W-1:0] CntMax = '1;

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d, mem_d, wb_d;
  slot_t id_slot;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic hazard;
  logic ex_dep, mem_dep, wb_dep;

  // Register 0 is hard-wired zero, so it can never be a producer.
  function automatic logic produces(input slot_t s, input logic [AW-1:0] r);
    return s.valid && s.regwrite && (s.dst == r) && (r != '0);
  endfunction

  function automatic logic idDepends(input slot_t s, input logic use_rs, input logic [AW-1:0] rs,
                                     input logic use_rt, input logic [AW-1:0] rt);
    return (use_rs && produces(s, rs)) || (use_rt && produces(s, rt));
  endfunction

  always_comb begin
    id_slot          = '0;
    id_slot.valid    = id_valid;
    id_slot.regwrite = id_regwrite;
    id_slot.memread  = id_memread;
    id_slot.use_rs   = id_use_rs;
    id_slot.use_rt   = id_use_rt;
    id_slot.dst      = id_dst;
    id_slot.rs       = id_rs;
    id_slot.rt       = id_rt;
  end

  assign ex_dep  = idDepends(ex_q,  id_use_rs, id_rs, id_use_rt, id_rt);
  assign mem_dep = idDepends(mem_q, id_use_rs, id_rs, id_use_rt, id_rt);
  assign wb_dep  = idDepends(wb_q,  id_use_rs, id_rs, id_use_rt, id_rt);

  // With forwarding only a load in EX is too late; without it every in-flight producer blocks.
  always_comb begin
    hazard = 1'b0;
    if (FWD_EN != 0) begin
      hazard = id_valid && ex_q.memread && ex_dep;
    end else begin
      hazard = id_valid && (ex_dep || mem_dep || wb_dep);
    end
  end

  assign flush       = mem_branch_taken && mem_q.valid;
  assign stall       = hazard && !flush;
  assign idex_bubble = stall || flush;

  assign id_byp_a = id_valid && id_use_rs && produces(wb_q, id_rs);
  assign id_byp_b = id_valid && id_use_rt && produces(wb_q, id_rt);

  // A load result is not ready in MEM, so only a non-load MEM producer can forward from there.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if ((FWD_EN != 0) && ex_q.valid) begin
      if (ex_q.use_rs && mem_q.valid && !mem_q.memread && produces(mem_q, ex_q.rs)) begin
        fwd_a = 2'b01;
      end else if (produces(wb_q, ex_q.rs)) begin
        fwd_a = 2'b10;
      end
      if (ex_q.use_rt && mem_q.valid && !mem_q.memread && produces(mem_q, ex_q.rt)) begin
        fwd_b = 2'b01;
      end else if (produces(wb_q, ex_q.rt)) begin
        fwd_b = 2'b10;
      end
    end
  end

  always_comb begin
    wb_d  = mem_q;
    mem_d = ex_q;
    ex_d  = id_slot;
    if (flush) begin
      mem_d = '0;
      ex_d  = '0;
    end else if (stall) begin
      ex_d  = '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Source fields of older slots are kept for debug visibility but not consumed.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{wb_q.memread, wb_q.use_rs, wb_q.use_rt, wb_q.rs, wb_q.rt,
                              mem_q.use_rs, mem_q.use_rt, mem_q.rs, mem_q.rt};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, no-forwarding and narrow-counter instances
// share one instruction stream and are checked against hand-derived values.
module tb_pipe_hazard_ctrl;

  logic clock;
  logic reset;
  logic idValid, idUseRs, idUseRt, idRegwrite, idMemread, memBranchTaken;
  logic [4:0] idRs, idRt, idDst;

  logic fStall, fBubble, fFlush, fBypA, fBypB;
  logic [1:0] fFwdA, fFwdB;
  logic [15:0] fStallCnt, fFlushCnt;

  logic nStall, nBubble, nFlush, nBypA, nBypB;
  logic [1:0] nFwdA, nFwdB;
  logic [15:0] nStallCnt, nFlushCnt;

  logic sStall, sBubble, sFlush, sBypA, sBypB;
  logic [1:0] sFwdA, sFwdB;
  logic [1:0] sStallCnt, sFlushCnt;

  int checks = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.AW(5), .FWD_EN(1), .CNT_W(16)) dutF (
    .Clk(clock), .Reset(reset), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(idUseRs), .id_use_rt(idUseRt), .id_dst(idDst), .id_regwrite(idRegwrite),
    .id_memread(idMemread), .mem_branch_taken(memBranchTaken),
    .stall(fStall), .idex_bubble(fBubble), .flush(fFlush), .fwd_a(fFwdA), .fwd_b(fFwdB),
    .id_byp_a(fBypA), .id_byp_b(fBypB), .stall_cnt(fStallCnt), .flush_cnt(fFlushCnt));

  pipe_hazard_ctrl #(.AW(5), .FWD_EN(0), .CNT_W(16)) dutN (
    .Clk(clock), .Reset(reset), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(idUseRs), .id_use_rt(idUseRt), .id_dst(idDst), .id_regwrite(idRegwrite),
    .id_memread(idMemread), .mem_branch_taken(memBranchTaken),
    .stall(nStall), .idex_bubble(nBubble), .flush(nFlush), .fwd_a(nFwdA), .fwd_b(nFwdB),
    .id_byp_a(nBypA), .id_byp_b(nBypB), .stall_cnt(nStallCnt), .flush_cnt(nFlushCnt));

  pipe_hazard_ctrl #(.AW(5), .FWD_EN(0), .CNT_W(2)) dutS (
    .Clk(clock), .Reset(reset), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(idUseRs), .id_use_rt(idUseRt), .id_dst(idDst), .id_regwrite(idRegwrite),
    .id_memread(idMemread), .mem_branch_taken(memBranchTaken),
    .stall(sStall), .idex_bubble(sBubble), .flush(sFlush), .fwd_a(sFwdA), .fwd_b(sFwdB),
    .id_byp_a(sBypA), .id_byp_b(sBypB), .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic [4:0] dst,
                               input logic rw, input logic mr);
    idValid    = v;
    idRs       = rs;
    idRt       = rt;
    idUseRs    = urs;
    idUseRt    = urt;
    idDst      = dst;
    idRegwrite = rw;
    idMemread  = mr;
  endtask

  task automatic applyNop();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic applyRandom();
    applyStimulus(1'b1, 5'($urandom), 5'($urandom), 1'b1, 1'b1, 5'($urandom), 1'b1, 1'($urandom));
  endtask

  // Advance past the next rising edge; inputs for the new cycle are set afterwards.
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    memBranchTaken = 1'b1;
    applyRandom();
    nextCycle();
    applyRandom();
    nextCycle();
    applyRandom();
    #1;
    checkOutput("rst_stall", fStall, 0);
    checkOutput("rst_bubble", fBubble, 0);
    checkOutput("rst_flush", fFlush, 0);
    checkOutput("rst_fwd", {fFwdA, fFwdB}, 0);
    checkOutput("rst_byp", {fBypA, fBypB}, 0);
    checkOutput("rst_cnt", {fStallCnt, fFlushCnt}, 0);
    checkOutput("rst_n_stall", nStall, 0);
    checkOutput("rst_n_byp", {nBypA, nBypB}, 0);
    checkOutput("rst_s_cnt", {sStallCnt, sFlushCnt}, 0);

    // add $3 followed directly by sub reading $3
    reset = 1'b1;
    memBranchTaken = 1'b0;
    applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
    nextCycle();
    applyStimulus(1, 5'd3, 5'd5, 1, 1, 5'd6, 1, 0);
    #1;
    checkOutput("f_add_sub_nostall", fStall, 0);
    nextCycle();
    applyNop();
    #1;
    checkOutput("f_fwd_a_mem", fFwdA, 2'b01);
    checkOutput("f_fwd_b_mem_none", fFwdB, 2'b00);
    checkOutput("f_fwd_mem_nostall", fStall, 0);

    // add $7, independent or, then sub reading $7
    nextCycle();
    applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0);
    nextCycle();
    applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0);
    nextCycle();
    applyStimulus(1, 5'd7, 5'd9, 1, 1, 5'd10, 1, 0);
    #1;
    checkOutput("f_gap_nostall", fStall, 0);
    nextCycle();
    applyNop();
    #1;
    checkOutput("f_fwd_a_wb", fFwdA, 2'b10);
    checkOutput("f_fwd_b_wb_none", fFwdB, 2'b00);

    // lw $4 then add reading $4 in rt
    nextCycle();
    applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd4, 1, 1);
    nextCycle();
    applyStimulus(1, 5'd2, 5'd4, 1, 1, 5'd11, 1, 0);
    #1;
    checkOutput("f_loaduse_stall", fStall, 1);
    checkOutput("f_loaduse_bubble", fBubble, 1);
    checkOutput("f_loaduse_flush", fFlush, 0);
    nextCycle();
    #1;
    checkOutput("f_loaduse_released", fStall, 0);
    checkOutput("f_loaduse_bubble_off", fBubble, 0);
    checkOutput("f_loaduse_cnt", fStallCnt, 1);
    nextCycle();
    applyNop();
    #1;
    checkOutput("f_loaduse_fwd_b", fFwdB, 2'b10);
    checkOutput("f_loaduse_fwd_a", fFwdA, 2'b00);
    checkOutput("f_loaduse_cnt_hold", fStallCnt, 1);

    // taken branch in MEM while a load-use hazard is pending
    nextCycle();
    applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd0, 0, 0);
    nextCycle();
    applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd12, 1, 1);
    nextCycle();
    applyStimulus(1, 5'd12, 5'd0, 1, 0, 5'd13, 1, 0);
    memBranchTaken = 1'b1;
    #1;
    checkOutput("f_flush_on", fFlush, 1);
    checkOutput("f_flush_over_stall", fStall, 0);
    checkOutput("f_flush_bubble", fBubble, 1);
    nextCycle();
    #1;
    checkOutput("f_flush_mem_cleared", fFlush, 0);
    checkOutput("f_flush_ex_cleared", fStall, 0);
    checkOutput("f_flush_cnt", fFlushCnt, 1);
    checkOutput("f_flush_stallcnt", fStallCnt, 1);

    // no-forwarding mode: add $3 then sub reading $3
    memBranchTaken = 1'b0;
    reset = 1'b0;
    applyNop();
    nextCycle();
    reset = 1'b1;
    applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
    #1;
    checkOutput("rst_f_flushcnt", fFlushCnt, 0);
    checkOutput("rst_n_stallcnt", nStallCnt, 0);
    nextCycle();
    applyStimulus(1, 5'd3, 5'd5, 1, 1, 5'd6, 1, 0);
    #1;
    checkOutput("n_stall1", nStall, 1);
    checkOutput("n_stall1_byp", nBypA, 0);
    checkOutput("n_fwd_const", {nFwdA, nFwdB}, 0);
    nextCycle();
    #1;
    checkOutput("n_stall2", nStall, 1);
    checkOutput("n_stall2_byp", nBypA, 0);
    nextCycle();
    #1;
    checkOutput("n_stall3", nStall, 1);
    checkOutput("n_stall3_byp", nBypA, 1);
    checkOutput("n_stall3_bubble", nBubble, 1);
    nextCycle();
    #1;
    checkOutput("n_released", nStall, 0);
    checkOutput("n_released_byp", nBypA, 0);
    checkOutput("n_stallcnt3", nStallCnt, 3);
    checkOutput("s_stallcnt3", sStallCnt, 3);

    // second dependency chain pushes the narrow counter past its ceiling
    nextCycle();
    applyStimulus(1, 5'd6, 5'd0, 1, 0, 5'd14, 1, 0);
    #1;
    checkOutput("n_chain2_stall", nStall, 1);
    nextCycle();
    nextCycle();
    nextCycle();
    #1;
    checkOutput("n_chain2_released", nStall, 0);
    checkOutput("n_stallcnt6", nStallCnt, 6);
    checkOutput("s_stallcnt_sat", sStallCnt, 3);

    // register 0 never creates a dependency
    nextCycle();
    applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0);
    nextCycle();
    applyStimulus(1, 5'd0, 5'd0, 1, 1, 5'd15, 1, 0);
    #1;
    checkOutput("z_n_stall", nStall, 0);
    checkOutput("z_f_stall", fStall, 0);
    nextCycle();
    applyStimulus(1, 5'd0, 5'd0, 1, 1, 5'd16, 1, 0);
    #1;
    checkOutput("z_f_fwd", {fFwdA, fFwdB}, 0);
    checkOutput("z_n_stall_mem", nStall, 0);
    nextCycle();
    applyStimulus(1, 5'd0, 5'd0, 1, 1, 5'd17, 1, 0);
    #1;
    checkOutput("z_f_byp", {fBypA, fBypB}, 0);
    checkOutput("z_n_byp", {nBypA, nBypB}, 0);
    checkOutput("z_n_stall_wb", nStall, 0);
    checkOutput("z_f_fwd_wb", {fFwdA, fFwdB}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
